// File: rtl/retire_trace_buffer_pkg.sv
// rtl/retire_trace_buffer_pkg.sv - shared types for retire trace capture: class enum, record layout, opcodes
package retire_trace_buffer_pkg;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_L,
    CLS_S,
    CLS_B,
    CLS_U,
    CLS_J,
    CLS_X
  } cls_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam int TRACE_SEQ_W = 16;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    cls_e                   cls;
    logic [31:0]            pc;
    logic [31:0]            instr;
    logic [31:0]            wb;
  } trace_rec_t;

  // Flat record width for a given sequence width: seq + cls + pc + instr + wb.
  function automatic int rec_w(input int seq_w);
    return seq_w + 3 + 96;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// rtl/retire_trace_buffer_if.sv - valid/ready drain stream carrying trace records
interface retire_trace_buffer_if #(
  parameter int REC_W = $bits(retire_trace_buffer_pkg::trace_rec_t)
);
  logic             out_valid_o;
  logic             out_ready_i;
  logic [REC_W-1:0] out_rec_o;

  modport master (output out_valid_o, output out_rec_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_rec_o, output out_ready_i);
endinterface

// File: rtl/retire_trace_buffer_classify.sv
// rtl/retire_trace_buffer_classify.sv - combinational opcode to instruction class decode
module retire_trace_buffer_classify
  import retire_trace_buffer_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls
);

  always_comb begin
    cls = CLS_X;
    case (opcode)
      OP_R:              cls = CLS_R;
      OP_I:              cls = CLS_I;
      OP_L:              cls = CLS_L;
      OP_S:              cls = CLS_S;
      OP_B:              cls = CLS_B;
      OP_LUI, OP_AUIPC:  cls = CLS_U;
      OP_JAL, OP_JALR:   cls = CLS_J;
      default:           cls = CLS_X;
    endcase
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - per-retire trace capture FIFO with drop accounting
// Optional TRACE_FILTER_EN: class_mask_i selects which instruction classes are stored.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     ret_valid_i,
  input  logic [31:0]              ret_pc_i,
  input  logic [31:0]              ret_instr_i,
  input  logic [31:0]              ret_wb_i,
  input  logic [7:0]               class_mask_i,
  retire_trace_buffer_if.master    out_if,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic                     overflow_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = rec_w(SEQ_W);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [SEQ_W-1:0]   seq_q;
  cls_e               cls;
  logic               captured;
  logic               push_req;
  logic               pop;
  logic               full;
  logic               accept;
  logic               drop;
  logic [REC_W-1:0]   new_rec;

  retire_trace_buffer_classify u_classify (
    .opcode (ret_instr_i[6:0]),
    .cls    (cls)
  );

`ifdef TRACE_FILTER_EN
  assign captured = class_mask_i[cls];
`else
  logic unused_class_mask;
  assign unused_class_mask = ^class_mask_i;
  assign captured          = 1'b1;
`endif

  assign count_o            = wr_ptr - rd_ptr;
  assign out_if.out_valid_o = (count_o != '0);
  // Gate the head so the record bus reads zero when empty and during reset.
  assign out_if.out_rec_o   = out_if.out_valid_o ? mem[rd_ptr[AW-1:0]] : '0;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = out_if.out_valid_o & out_if.out_ready_i;
  assign push_req = ret_valid_i & captured;
  assign accept   = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign new_rec  = {seq_q, cls, ret_pc_i, ret_instr_i, ret_wb_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq_q      <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq_q      <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      // Every retire consumes a sequence number so consumers can spot gaps.
      if (ret_valid_i) seq_q <= seq_q + 1'b1;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i && accept) mem[wr_ptr[AW-1:0]] <= new_rec;
  end

endmodule
